// File: rtl/svm_pkg.sv
// svm_pkg: shared formats, widths, FSM states and
// saturation bounds for the cascaded SVM datapath.
package svm_pkg;

  localparam int KERN_W     = 16;
  localparam int Q88_FRAC   = 8;
  localparam int Q1616_FRAC = 16;
  localparam int PROD_W     = 2 * KERN_W + 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_WAIT_K = 3'd2;
  localparam state_t ST_MAC    = 3'd3;
  localparam state_t ST_BIAS   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Largest value of a w-bit signed word
  function automatic longint sat_max(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value of a w-bit signed word
  function automatic longint sat_min(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/svm_sat_add.sv
// svm_sat_add: signed saturating adder, clamps
// to the W-bit range and flags the clamp.
import svm_pkg::*;

module svm_sat_add #(
  parameter int W = 40
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] HI = W'(sat_max(W));
  localparam logic signed [W-1:0] LO = W'(sat_min(W));

  logic [W:0] full;

  // One guard bit exposes overflow; clamp on sign of the true sum
  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    ovf  = full[W] ^ full[W-1];
    sum  = full[W-1:0];
    if (ovf) sum = full[W] ? LO : HI;
  end

endmodule

// File: rtl/svm_decision_acc.sv
// svm_decision_acc: accumulates coef*K over all support
// vectors, adds bias, emits decision value and class.
import svm_pkg::*;

module svm_decision_acc #(
  parameter int XLEN_PIXEL = 8,
  parameter int NUM_OF_SV  = 87,
  parameter int ACC_W      = 40,
  parameter int BIAS_W     = 32,
  localparam int KW = 2 * XLEN_PIXEL,
  localparam int PW = 2 * KW + 1,
  localparam int AW = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    kern_valid,
  input  logic [KW-1:0]           kern_in,
  output logic                    kern_ready,
  output logic [AW-1:0]           coef_addr,
  input  logic signed [KW-1:0]    coef_data,
  input  logic signed [BIAS_W-1:0] bias,
  output logic                    busy,
  output logic                    dec_valid,
  output logic signed [ACC_W-1:0] dec_value,
  output logic                    dec_class,
  output logic                    overflow
);

  state_t                  state;
  logic [AW-1:0]           idx;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    last;

  assign kern_ready = (state == ST_WAIT_K);
  assign last       = (idx == AW'(NUM_OF_SV - 1));
  assign prod_ext   = ACC_W'(prod);
  assign bias_ext   = ACC_W'(bias);

  // Single adder shared between the MAC and bias steps
  assign addend = (state == ST_BIAS) ? bias_ext : prod_ext;

  svm_sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (addend),
    .sum (sum),
    .ovf (ovf)
  );

  // Decision FSM and accumulator datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      coef_addr <= '0;
      prod      <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      dec_valid <= 1'b0;
      dec_value <= '0;
      dec_class <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            acc       <= '0;
            idx       <= '0;
            coef_addr <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_WAIT_K;
        end
        ST_WAIT_K: begin
          if (kern_valid) begin
            prod  <= PW'($signed({1'b0, kern_in}))
                   * PW'(coef_data);
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc      <= sum;
          overflow <= overflow | ovf;
          if (last) begin
            state <= ST_BIAS;
          end else begin
            idx       <= idx + 1'b1;
            coef_addr <= idx + 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_BIAS: begin
          acc      <= sum;
          overflow <= overflow | ovf;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          dec_value <= acc;
          dec_class <= ~acc[ACC_W-1];
          dec_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svm_decision_acc.sv
// tb_svm_decision_acc: directed checks of the decision
// accumulator, 4 SVs, plus a 33-bit saturation copy.
module tb_svm_decision_acc;

  localparam int NSV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kern_valid = 1'b0;
  logic [15:0] kern_in = '0;
  logic signed [31:0] bias = '0;
  logic [15:0] rom [NSV];

  logic        kr_a, busy_a, dv_a, dc_a, ov_a;
  logic [1:0]  ca_a;
  logic [15:0] cd_a;
  logic [39:0] val_a;

  logic        kr_b, busy_b, dv_b, dc_b, ov_b;
  logic [1:0]  ca_b;
  logic [15:0] cd_b;
  logic [32:0] val_b;

  int n_chk = 0;
  int n_pass = 0;
  int lat;
  logic ok;

  always #5 clk = ~clk;

  // ROM models with one-cycle read latency
  always @(posedge clk) begin
    cd_a <= rom[ca_a];
    cd_b <= rom[ca_b];
  end

  svm_decision_acc #(
    .NUM_OF_SV (NSV)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kern_valid (kern_valid),
    .kern_in    (kern_in),
    .kern_ready (kr_a),
    .coef_addr  (ca_a),
    .coef_data  (cd_a),
    .bias       (bias),
    .busy       (busy_a),
    .dec_valid  (dv_a),
    .dec_value  (val_a),
    .dec_class  (dc_a),
    .overflow   (ov_a)
  );

  svm_decision_acc #(
    .NUM_OF_SV (NSV),
    .ACC_W     (33)
  ) u_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kern_valid (kern_valid),
    .kern_in    (kern_in),
    .kern_ready (kr_b),
    .coef_addr  (ca_b),
    .coef_data  (cd_b),
    .bias       (bias),
    .busy       (busy_b),
    .dec_valid  (dv_b),
    .dec_value  (val_b),
    .dec_class  (dc_b),
    .overflow   (ov_b)
  );

  task automatic check(string tag, longint obs, longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, obs, exp);
  endtask

  task automatic wait_dv(output int cyc);
    cyc = 0;
    while (!dv_a && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("dv_timeout", longint'(dv_a), 1);
  endtask

  task automatic run_dec(output int cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_dv(cyc);
  endtask

  task automatic load_mixed();
    rom[0] = 16'h0100;
    rom[1] = 16'hFF00;
    rom[2] = 16'h0200;
    rom[3] = 16'h0080;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NSV; i++) rom[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset held mid-idle
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", longint'(busy_a), 0);
    check("rst_kready", longint'(kr_a), 0);
    check("rst_dvalid", longint'(dv_a), 0);
    check("rst_value", $signed(val_a), 0);
    check("rst_class", longint'(dc_a), 0);
    check("rst_ovf", longint'(ov_a), 0);
    check("rst_addr", longint'(ca_a), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 2: mixed-sign sum, kern_valid tied high
    load_mixed();
    kern_in    = 16'h0100;
    kern_valid = 1'b1;
    bias       = '0;
    run_dec(lat);
    check("mix_latency", lat, 14);
    check("mix_value", $signed(val_a), 163840);
    check("mix_class", longint'(dc_a), 1);
    check("mix_ovf", longint'(ov_a), 0);
    check("mix_busy", longint'(busy_a), 0);
    check("mix_addr_max", longint'(ca_a), 3);
    check("mix_value33", $signed(val_b), 163840);
    @(posedge clk); #1;
    check("mix_pulse", longint'(dv_a), 0);
    check("mix_hold", $signed(val_a), 163840);

    // 3: negative sum with positive bias
    for (int i = 0; i < NSV; i++) rom[i] = 16'hFF00;
    bias = 32'sh0001_0000;
    run_dec(lat);
    check("neg_value", $signed(val_a), -196608);
    check("neg_class", longint'(dc_a), 0);
    check("neg_ovf", longint'(ov_a), 0);

    // 4: saturation in the 33-bit copy
    for (int i = 0; i < NSV; i++) rom[i] = 16'h7FFF;
    kern_in = 16'hFFFF;
    bias    = '0;
    run_dec(lat);
    check("sat_value", $signed(val_b), 64'sd4294967295);
    check("sat_ovf", longint'(ov_b), 1);
    check("sat_class", longint'(dc_b), 1);
    check("wide_value", $signed(val_a), 64'sd8589541380);
    check("wide_ovf", longint'(ov_a), 0);

    // 5: stalls, LOAD-time kern pulse, start while busy
    load_mixed();
    kern_in    = 16'h0100;
    kern_valid = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ovf_cleared", longint'(ov_b), 0);
    check("load_kready", longint'(kr_a), 0);
    kern_valid = 1'b1;
    kern_in    = 16'hFFFF;
    @(posedge clk); #1;
    kern_valid = 1'b0;
    kern_in    = 16'h0100;
    start      = 1'b1;
    ok         = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!kr_a || !busy_a || dv_a) ok = 1'b0;
    end
    check("stall_hold", longint'(ok), 1);
    kern_valid = 1'b1;
    wait_dv(lat);
    check("stall_value", $signed(val_a), 163840);
    check("stall_ovf33", longint'(ov_b), 0);

    // 6: reset after idx reaches 2
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_addr", longint'(ca_a), 2);
    rst = 1'b0;
    #1;
    check("mid_busy", longint'(busy_a), 0);
    check("mid_kready", longint'(kr_a), 0);
    check("mid_value", $signed(val_a), 0);
    check("mid_addr_rst", longint'(ca_a), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    ok  = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (dv_a || busy_a) ok = 1'b1;
    end
    check("mid_no_dv", longint'(ok), 0);
    run_dec(lat);
    check("rerun_latency", lat, 14);
    check("rerun_value", $signed(val_a), 163840);
    check("rerun_class", longint'(dc_a), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
